// File: rtl/cfg_scan_pkg.sv
// Shared types and width helpers for the scan-chain configuration loader.
// Counter widths are derived from DATA_W and CHAIN_LEN/DATA_W.
package cfg_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_PUSH,
    ST_DONE
  } cfg_state_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CHAIN_LEN = 64;
  localparam int DEF_BIT_W     = $clog2(DEF_DATA_W);
  localparam int DEF_WORD_W    = $clog2(DEF_CHAIN_LEN / DEF_DATA_W);

  // Zero-width counters are illegal, so clamp to one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_scan_shreg.sv
// Word-wide PISO feeding the chain head and SIPO capturing the chain tail.
// Both registers advance on the same shift enable.
module cfg_scan_shreg
  import cfg_scan_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              shift_i,
  input  logic              sdi_i,
  output logic              sdo_o,
  output logic [DATA_W-1:0] par_o
);

  logic [DATA_W-1:0] piso_q, piso_d;
  logic [DATA_W-1:0] sipo_q, sipo_d;

  always_comb begin
    piso_d = piso_q;
    sipo_d = sipo_q;
    if (load_i) begin
      piso_d = data_i;
    end else if (shift_i) begin
      piso_d = {1'b0, piso_q[DATA_W-1:1]};
    end
    // New bits enter at the MSB so the first one ends up in the LSB.
    if (shift_i) begin
      sipo_d = {sdi_i, sipo_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piso_q <= '0;
      sipo_q <= '0;
    end else begin
      piso_q <= piso_d;
      sipo_q <= sipo_d;
    end
  end

  assign sdo_o = piso_q[0];
  assign par_o = sipo_q;

endmodule

// File: rtl/cfg_scan_loader.sv
// Streams config words into a scan chain while reading back old contents.
// cfg_done is only reached through a complete, unaborted load.
module cfg_scan_loader
  import cfg_scan_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic              CK,
  input  logic              R,
  input  logic              start,
  input  logic              abort,
  input  logic              bs_valid,
  output logic              bs_ready,
  input  logic [DATA_W-1:0] bs_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic [DATA_W-1:0] rb_data,
  output logic              SE,
  output logic              SI,
  input  logic              SO,
  output logic              cfg_done,
  output logic              busy
);

  localparam int WORDS  = CHAIN_LEN / DATA_W;
  localparam int BIT_W  = cnt_w(DATA_W);
  localparam int WORD_W = cnt_w(WORDS);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);

  cfg_state_e        state_q, state_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              load;
  logic              shift;
  logic              sdo;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    word_d  = word_q;
    load    = 1'b0;
    shift   = (state_q == ST_SHIFT);
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          word_d = WORD_LAST;
          if (start) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (bs_valid) begin
            load    = 1'b1;
            bit_d   = BIT_LAST;
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_q == '0) state_d = ST_PUSH;
          else             bit_d   = bit_q - BIT_W'(1);
        end
        ST_PUSH: begin
          if (rb_ready) begin
            if (word_q == '0) begin
              state_d = ST_DONE;
            end else begin
              word_d  = word_q - WORD_W'(1);
              state_d = ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            word_d  = WORD_LAST;
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CK or negedge R) begin
    if (!R) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
    end
  end

  cfg_scan_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk     (CK),
    .rst_n   (R),
    .load_i  (load),
    .data_i  (bs_data),
    .shift_i (shift),
    .sdi_i   (SO),
    .sdo_o   (sdo),
    .par_o   (rb_data)
  );

  assign SE       = (state_q == ST_SHIFT);
  assign SI       = SE & sdo;
  assign bs_ready = (state_q == ST_FETCH);
  assign rb_valid = (state_q == ST_PUSH);
  assign cfg_done = (state_q == ST_DONE);
  assign busy     = (state_q == ST_FETCH) |
                    (state_q == ST_SHIFT) |
                    (state_q == ST_PUSH);

endmodule
